// File: rtl/timebase_ctrl.sv
// timebase_ctrl: 1-2-5 stepped sample-rate divider with period-aligned rate changes
module timebase_ctrl #(
  parameter int FREQ_IN = 100_000_000,
  parameter int BASE_FREQ = 1,
  parameter int NUM_STEPS = 22,
  parameter int DEFAULT_INDEX = 12,
  localparam int IW = $clog2(NUM_STEPS)
) (
  input logic clk_in,
  input logic rst,
  input logic run,
  input logic step_up,
  input logic step_down,
  output logic sample_tick,
  output logic [IW-1:0] tb_index,
  output logic [31:0] freq,
  output logic busy,
  output logic cfg_changed,
  output logic limit_hit
);
  function automatic logic [31:0] rate_f(input int i);
    logic [31:0] r;
    r = (i % 3 == 0) ? 32'd1 : (i % 3 == 1) ? 32'd2 : 32'd5;
    for (int k = 0; k < i / 3; k++) r = r * 32'd10;
    return r * 32'(BASE_FREQ);
  endfunction
  function automatic logic [31:0] term_f(input int i);
    return 32'(FREQ_IN) / rate_f(i) - 32'd1;
  endfunction
  if (rate_f(NUM_STEPS - 1) > 32'(FREQ_IN / 2) || DEFAULT_INDEX >= NUM_STEPS) begin : g_bad_params
    $error("timebase_ctrl: table exceeds FREQ_IN/2 or DEFAULT_INDEX out of range");
  end
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;
  state_t state, nxt;
  logic [31:0] rate_tab [NUM_STEPS];
  logic [31:0] term_tab [NUM_STEPS];
  logic [31:0] cnt, term;
  logic [IW-1:0] pend_idx, tgt;
  logic wrap, req, at_end;
  for (genvar i = 0; i < NUM_STEPS; i++) begin : g_tab
    assign rate_tab[i] = rate_f(i);
    assign term_tab[i] = term_f(i);
  end
  always_comb begin
    wrap = cnt == term;
    req = step_up ^ step_down;
    at_end = step_up ? (tb_index == IW'(NUM_STEPS - 1)) : (tb_index == '0);
    tgt = step_up ? tb_index + 1'b1 : tb_index - 1'b1;
    nxt = (state == IDLE) ? ((req && !at_end) ? PENDING : IDLE) :
          (state == PENDING) ? ((wrap || !run) ? APPLY : PENDING) : IDLE;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      term <= term_f(DEFAULT_INDEX);
      freq <= rate_f(DEFAULT_INDEX);
      tb_index <= IW'(DEFAULT_INDEX);
      pend_idx <= IW'(DEFAULT_INDEX);
      sample_tick <= 1'b0;
      busy <= 1'b0;
      cfg_changed <= 1'b0;
      limit_hit <= 1'b0;
    end else begin
      cnt <= (!run || wrap) ? '0 : cnt + 32'd1;
      sample_tick <= run && wrap;
      busy <= nxt != IDLE;
      cfg_changed <= state == APPLY;
      limit_hit <= state == IDLE && req && at_end;
      if (state == IDLE) pend_idx <= tgt;
      if (state == APPLY) begin
        tb_index <= pend_idx;
        freq <= rate_tab[pend_idx];
        term <= term_tab[pend_idx];
      end
    end
  end
endmodule
